// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO owner sequencing mult/multu/div/divu beside the EX stage
// Optional MULDIV_ABORT_EN adds an abort input that kills the in-flight operation.
module muldiv_sequencer #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MULDIV_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  input  logic        hilo_rd,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_b, r_rem, r_quo, r_hi, r_lo;
  logic [63:0] r_prod;
  logic        r_neg_q, r_neg_r, r_is_mul;

  logic        w_abort, w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b, w_quo_s, w_rem_s;
  logic [32:0] w_sh, w_diff;
  logic [63:0] w_prod_s;

`ifdef MULDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // op[0] clear selects the signed variants
  assign w_sa    = ~op[0] & opa[31];
  assign w_sb    = ~op[0] & opb[31];
  assign w_abs_a = w_sa ? (32'd0 - opa) : opa;
  assign w_abs_b = w_sb ? (32'd0 - opb) : opb;

  // Bit 32 of the difference is the borrow: set when the shifted remainder is below the divisor
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_diff = w_sh - {1'b0, r_b};

  assign w_prod_s = r_neg_q ? (64'd0 - r_prod) : r_prod;
  assign w_quo_s  = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_rem_s  = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_prod   <= 64'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_mul <= 1'b0;
    end else if (w_abort && r_state != S_IDLE) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !w_abort) begin
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_is_mul <= ~op[1];
            if (!op[1]) begin
              r_state <= S_MUL;
              r_cnt   <= 5'(MUL_LATENCY - 1);
            end else if (opb == 32'd0) begin
              // Divide-by-zero result is raw and sign-independent
              r_state <= S_FIX;
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= opa;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_state <= S_DIV;
              r_cnt   <= 5'd31;
              r_rem   <= 32'd0;
              r_quo   <= w_abs_a;
            end
          end else if (!start) begin
            if (mthi_we) r_hi <= mt_data;
            if (mtlo_we) r_lo <= mt_data;
          end
        end
        S_MUL: begin
          r_prod <= 64'(r_a) * 64'(r_b);
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= S_FIX;
        end
        S_DIV: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_mul) begin
            r_hi <= w_prod_s[63:32];
            r_lo <= w_prod_s[31:0];
          end else begin
            r_hi <= w_rem_s;
            r_lo <= w_quo_s;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_FIX);
  assign stall = busy & (start | mthi_we | mtlo_we | hilo_rd);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
// Vector table, hand-written hazard/reset sequences and randomized ops against an arithmetic model.
module tb_muldiv_sequencer;
  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        reset, start, mthi_we, mtlo_we, hilo_rd;
  logic [1:0]  op;
  logic [31:0] opa, opb, mt_data;
  logic        stall, busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MUL_LATENCY(ML)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .op(op),
    .opa(opa),
    .opb(opb),
    .mthi_we(mthi_we),
    .mtlo_we(mtlo_we),
    .mt_data(mt_data),
    .hilo_rd(hilo_rd),
    .stall(stall),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int model_cyc(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return ML + 1;
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Issue one op starting at a negedge; returns result and edges from acceptance to done
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rhi, output logic [31:0] rlo, output int cyc);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
    @(negedge clk);
    rhi = hi;
    rlo = lo;
  endtask

  task automatic mt_write(input logic sel_hi, input logic [31:0] d);
    mthi_we = sel_hi; mtlo_we = ~sel_hi; mt_data = d;
    @(posedge clk);
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rhi, rlo;
    logic [63:0] exp;
    int          cyc, n_st, w, n_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{"mult_m3x7",    2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, ML + 1};
    vecs[1] = '{"divu_100_7",   2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[2] = '{"div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    vecs[3] = '{"div_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{"div_7_m2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    vecs[5] = '{"divu_5_0",     2'b11, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
    vecs[6] = '{"div_m7_0",     2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[7] = '{"multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        ML + 1};
    vecs[8] = '{"mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        ML + 1};
    vecs[9] = '{"divu_max_1",   2'b11, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};

    reset = 1'b0; start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; hilo_rd = 1'b0;
    op = 2'b00; opa = 32'd0; opb = 32'd0; mt_data = 32'd0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, cyc);
      check({vecs[i].name, "_hi"}, rhi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, rlo, vecs[i].lo);
      check({vecs[i].name, "_cyc"}, 64'(cyc), 64'(vecs[i].cyc));
      check({vecs[i].name, "_idle"}, {busy, done}, 2'b00);
    end

    mt_write(1'b1, 32'h1234_5678);
    check("mthi", hi, 32'h1234_5678);
    mt_write(1'b0, 32'h5555_5555);
    check("mtlo", lo, 32'h5555_5555);

    // start and mtlo in the same IDLE cycle: start wins
    start = 1'b1; op = 2'b11; opa = 32'd9; opb = 32'd0; mtlo_we = 1'b1; mt_data = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mtlo_we = 1'b0;
    check("start_wins_lo", lo, 32'h5555_5555);
    check("dz_done", done, 1);
    @(negedge clk);
    check("start_wins_res_lo", lo, 32'hFFFF_FFFF);
    check("start_wins_res_hi", hi, 32'd9);

    // hilo_rd two cycles into a divu
    start = 1'b1; op = 2'b11; opa = 32'd1000; opb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_st = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      hilo_rd = (k >= 2);
      #1;
      if (stall) n_st++;
      if (k == 33) check("hz_stall_at_done", {stall, done}, 2'b11);
      if (k == 34) begin
        check("hz_stall_after", stall, 0);
        check("hz_hi", hi, 32'd1);
        check("hz_lo", lo, 32'd333);
      end
    end
    hilo_rd = 1'b0;
    check("hz_stall_cycles", 64'(n_st), 64'd32);

    // second start while a mult is in flight; held instruction issues afterwards
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFB; opb = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; opa = 32'd50; opb = 32'd0;
    #1;
    check("restart_stall", stall, 1);
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("restart_idle", busy, 0);
    check("restart_mult_hi", hi, 32'hFFFF_FFFF);
    check("restart_mult_lo", lo, 32'hFFFF_FFE2);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_second_done", done, 1);
    @(negedge clk);
    check("restart_second_hi", hi, 32'd50);
    check("restart_second_lo", lo, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      do_op(ro, ra, rb, rhi, rlo, cyc);
      exp = model(ro, ra, rb);
      check($sformatf("rnd%0d_op%0d_hi", i, ro), rhi, exp[63:32]);
      check($sformatf("rnd%0d_op%0d_lo", i, ro), rlo, exp[31:0]);
      check($sformatf("rnd%0d_op%0d_cyc", i, ro), 64'(cyc), 64'(model_cyc(ro, rb)));
    end

    // async reset in the middle of a divide
    mt_write(1'b1, 32'h1111_1111);
    start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    hilo_rd = 1'b1;
    #1;
    check("pre_rst_stall", stall, 1);
    reset = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_stall", stall, 0);
    check("midrst_done", done, 0);
    hilo_rd = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, rhi, rlo, cyc);
    check("postrst_hi", rhi, 32'hFFFF_FFFF);
    check("postrst_lo", rlo, 32'hFFFF_FFEB);
    check("postrst_cyc", 64'(cyc), 64'(ML + 1));

`ifdef MULDIV_ABORT_EN
    mt_write(1'b1, 32'h0000_0011);
    mt_write(1'b0, 32'h0000_0022);
    start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_hi", hi, 32'h11);
    check("abort_lo", lo, 32'h22);

    start = 1'b1; op = 2'b11; opa = 32'd5; opb = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_fix_done", done, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_fix_hi", hi, 32'h11);
    check("abort_fix_lo", lo, 32'h22);
    check("abort_fix_busy", busy, 0);

    start = 1'b1; abort = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
